matmul_seq_ctrl: RTL and testbench
==================================

MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 SHALL take parameter N, default 2, matrix dimension (N x N); legal range 1..8.
REQ-002 SHALL take parameter DW, default 32, operand element width in bits.
REQ-003 SHALL define localparam ACC_W = 2*DW + clog2(N) (min +1), result element width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin a new operation; honoured only in IDLE.
REQ-007 SHALL have port in_valid  input  1  in_data holds a valid operand element.
REQ-008 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-009 SHALL have port in_data  input  DW  operand element, row-major; A first, then B.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid result element.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 SHALL have port out_data  output  ACC_W  result element C[i][j], row-major.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last result handshake.

Function
REQ-015 SHALL implement states IDLE, LOAD_A, LOAD_B, COMPUTE, OUT.
REQ-016 IDLE: start=1 SHALL move to LOAD_A on the next edge; start outside IDLE SHALL be ignored.
REQ-017 Input handshake SHALL occur on an edge where in_valid && in_ready; in_ready SHALL be high only in LOAD_A and LOAD_B.
REQ-018 LOAD_A SHALL store N*N elements into A[r][c] row-major, then move to LOAD_B on the edge accepting the last element.
REQ-019 LOAD_B SHALL store N*N elements into B likewise, then move to COMPUTE with i=j=k=0.
REQ-020 COMPUTE SHALL do one MAC per cycle: acc <= (k==0 ? 0 : acc) + A[i][k]*B[k][j], k incrementing 0..N-1.
REQ-021 The edge performing k=N-1 SHALL move to OUT and register acc onto out_data.
REQ-022 The first out_valid SHALL be visible after the Nth rising edge following the edge accepting the last B element.
REQ-023 OUT SHALL hold out_valid=1 and out_data stable until out_ready=1; stalls of any length SHALL be tolerated.
REQ-024 On an OUT handshake with (i,j) != (N-1,N-1), SHALL advance j (wrapping to 0 and incrementing i) and return to COMPUTE.
REQ-025 On the OUT handshake with (i,j) == (N-1,N-1), SHALL go to IDLE and pulse done for exactly the next cycle.
REQ-026 Arithmetic SHALL be full-precision in ACC_W bits; no overflow is possible.
REQ-027 N=1 SHALL work: one A, one B, one COMPUTE cycle, one result.
REQ-028 start asserted together with the done pulse SHALL be accepted, since the state is IDLE then.

Reset
REQ-029 reset_n low SHALL force IDLE immediately and clear all counters and acc.
REQ-030 During reset, in_ready, out_valid, busy and done SHALL be 0, and out_data SHALL be 0.
REQ-031 Reset mid-operation SHALL discard partial data; the next start SHALL require a full reload.

Configuration
REQ-032 Macro MATMUL_SEQ_SIGNED_EN defined: operands and results SHALL be two's complement, with sign-extended products.
REQ-033 MATMUL_SEQ_SIGNED_EN undefined: operands and results SHALL be unsigned.

Structure
REQ-034 Package matmul_seq_pkg SHALL hold the state enum and the ACC_W width function.
REQ-035 The MAC datapath SHALL be sub-module matmul_mac_unit (operands, clear, enable -> acc).

Verification
REQ-036 N=2, DW=32: A=[1,2,3,4], B=[5,6,7,8], out_ready=1 -> outputs 19,22,43,50, then one done pulse.
REQ-037 Same stimulus with out_ready low 5 cycles per element -> out_data stable while stalled, same 4 values, one done.
REQ-038 Signed build, N=2: A=[-1,2,3,-4], B=[5,-6,7,8] -> outputs 9,22,-13,-50.
REQ-039 N=1: A=7, B=6 -> single output 42, out_valid 1 cycle after B is accepted, done pulse after it.
REQ-040 reset_n low midway through LOAD_B -> busy=0, in_ready=0 at once; restart with the REQ-036 data reproduces REQ-036.
REQ-041 start pulsed during COMPUTE and in_valid held during COMPUTE -> no effect; results unchanged.

Source files
------------

// File: rtl/matmul_seq_pkg.sv
// matmul_seq_pkg: controller state encoding and result-width helper shared by the matmul_seq blocks.
package matmul_seq_pkg;

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUT} state_t;

   // A sum of n products of dw-bit operands needs clog2(n) guard bits; keep at least one.
   function automatic int acc_w(input int n, input int dw);
      return 2 * dw + ((n > 1) ? $clog2(n) : 1);
   endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// matmul_mac_unit: one multiply-accumulate per enabled cycle; clear restarts the sum.
// Operands are two's complement when MATMUL_SEQ_SIGNED_EN is defined, unsigned otherwise.
module matmul_mac_unit #(
   parameter int DW    = 32,
   parameter int ACC_W = 65
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   input  logic             clear,
   input  logic             en,
   output logic [ACC_W-1:0] acc
);
`ifdef MATMUL_SEQ_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif
   logic            sa, sb;
   logic [2*DW-1:0] prod;
   logic [ACC_W-1:0] prod_ext;
   // Extending both operands to 2*DW makes the low half of the product exact in either mode.
   assign sa       = SGN && a[DW-1];
   assign sb       = SGN && b[DW-1];
   assign prod     = {{DW{sa}}, a} * {{DW{sb}}, b};
   assign prod_ext = {{(ACC_W-2*DW){SGN && prod[2*DW-1]}}, prod};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) acc <= '0;
      else if (en) acc <= (clear ? '0 : acc) + prod_ext;
endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: streams A then B in row-major order, computes C = A*B one MAC per cycle, streams C out.
// Define MATMUL_SEQ_SIGNED_EN for two's-complement operands and results.
module matmul_seq_ctrl
   import matmul_seq_pkg::*;
#(
   parameter  int N     = 2,
   parameter  int DW    = 32,
   localparam int ACC_W = acc_w(N, DW)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             busy,
   output logic             done
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   if (N < 1 || N > 8) begin : g_bad_n
      $error("matmul_seq_ctrl: N must be in 1..8");
   end

   state_t        state, state_next;
   logic [IW-1:0] i, j, k;
   logic [DW-1:0] a_mem [N][N];
   logic [DW-1:0] b_mem [N][N];
   logic          in_fire, out_fire, row_end, mat_end, k_end;

   assign in_fire  = in_valid && (state == LOAD_A || state == LOAD_B);
   assign out_fire = out_ready && state == OUT;
   assign row_end  = j == LAST;
   assign mat_end  = row_end && i == LAST;
   assign k_end    = k == LAST;

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = state != IDLE;
      case (state)
         IDLE:    if (start) state_next = LOAD_A;
         LOAD_A: begin
            in_ready = 1'b1;
            if (in_valid && mat_end) state_next = LOAD_B;
         end
         LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid && mat_end) state_next = COMPUTE;
         end
         COMPUTE: if (k_end) state_next = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = mat_end ? IDLE : COMPUTE;
         end
         default: state_next = IDLE;
      endcase
   end

   // (i,j) walk row-major while loading and again while emitting; every pass ends back at (0,0).
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= out_fire && mat_end;
         if (in_fire || out_fire) begin
            j <= row_end ? '0 : j + IW'(1);
            if (row_end) i <= mat_end ? '0 : i + IW'(1);
         end
         if (state == COMPUTE) k <= k_end ? '0 : k + IW'(1);
      end

   always_ff @(posedge clk)
      if (in_fire) begin
         if (state == LOAD_A) a_mem[i][j] <= in_data;
         else b_mem[i][j] <= in_data;
      end

   // The accumulator only moves in COMPUTE, so it doubles as the held result register in OUT.
   matmul_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (a_mem[i][k]),
      .b       (b_mem[k][j]),
      .clear   (k == '0),
      .en      (state == COMPUTE),
      .acc     (out_data)
   );
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: randomized scoreboard bench for matmul_seq_ctrl (N=2 main instance, N=1 side instance).
module tb_matmul_seq_ctrl;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 2 * DW + 1;
   localparam int NN = N * N;
   typedef logic [AW-1:0] res_t;
   typedef logic [DW-1:0] op_t;

   logic clk = 1'b0, reset_n = 1'b0;
   logic start = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready, busy, done;
   op_t  in_data = '0;
   res_t out_data;
   logic start1 = 1'b0, in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1, busy1, done1;
   op_t  in_data1 = '0;
   res_t out_data1;

   matmul_seq_ctrl #(.N(N), .DW(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done));

   matmul_seq_ctrl #(.N(1), .DW(DW)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .busy(busy1), .done(done1));

   always #5 clk = ~clk;

   int   n_chk = 0, n_fail = 0, ready_mode = 0;
   res_t exp_q[$], exp1_q[$];
   bit   pend_done = 0, pend_done1 = 0, stall_prev = 0, lat_pend = 0, lat_pend1 = 0;
   res_t stall_data;
   time  t_b, t_b1;

   task automatic chk(input string nm, input res_t act, input res_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic res_t ext(input op_t x);
`ifdef MATMUL_SEQ_SIGNED_EN
      return {{(AW-DW){x[DW-1]}}, x};
`else
      return {{(AW-DW){1'b0}}, x};
`endif
   endfunction

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j], emitted row-major.
   task automatic push_expected(input op_t a[NN], input op_t b[NN]);
      res_t s;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            s = '0;
            for (int m = 0; m < N; m++) s += ext(a[r*N+m]) * ext(b[m*N+c]);
            exp_q.push_back(s);
         end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         pend_done  = 1'b0;
         pend_done1 = 1'b0;
         stall_prev = 1'b0;
      end else begin
         chk("done", res_t'(done), res_t'(pend_done));
         pend_done = 1'b0;
         if (stall_prev) begin
            chk("stall_valid", res_t'(out_valid), 1);
            chk("stall_data", out_data, stall_data);
         end
         if (lat_pend && out_valid) begin
            chk("latency", res_t'($time - t_b), res_t'(N * 10 + 5));
            lat_pend = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", res_t'(out_valid), 0);
            else begin
               chk("out_data", out_data, exp_q.pop_front());
               pend_done = exp_q.size() == 0;
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
         chk("done1", res_t'(done1), res_t'(pend_done1));
         pend_done1 = 1'b0;
         if (lat_pend1 && out_valid1) begin
            chk("latency1", res_t'($time - t_b1), res_t'(15));
            lat_pend1 = 1'b0;
         end
         if (out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) chk("unexpected_out1", res_t'(out_valid1), 0);
            else begin
               chk("out_data1", out_data1, exp1_q.pop_front());
               pend_done1 = exp1_q.size() == 0;
            end
         end
      end
   end

   // Consumer: 0 = always ready, 1 = random, 2 = hold each result for 5 stalled cycles.
   initial begin
      int rcnt;
      rcnt       = 0;
      out_ready  = 1'b1;
      out_ready1 = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 0) out_ready = 1'b1;
         else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
         else begin
            out_ready = out_valid && rcnt >= 5;
            rcnt = (!out_valid || out_ready) ? 0 : rcnt + 1;
         end
      end
   end

   task automatic feed(input op_t v[2*NN], input int cnt, input bit gaps);
      int tries;
      for (int n = 0; n < cnt; n++) begin
         while (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = v[n];
         tries    = 0;
         @(negedge clk);
         while (!in_ready && tries < 50) begin
            tries++;
            @(negedge clk);
         end
         chk("in_ready", res_t'(in_ready), 1);
         @(posedge clk);
         if (n == 2 * NN - 1) begin
            t_b      = $time;
            lat_pend = 1'b1;
         end
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("results_left", res_t'(exp_q.size()), 0);
      chk("idle", res_t'(busy), 0);
   endtask

   // cnt < 2*NN aborts the operation with a reset after cnt operands.
   task automatic run_op(input op_t a[NN], input op_t b[NN], input int mode, input bit gaps,
                         input bit noise, input int cnt);
      op_t v[2*NN];
      for (int n = 0; n < NN; n++) begin
         v[n]      = a[n];
         v[n + NN] = b[n];
      end
      ready_mode = mode;
      push_expected(a, b);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      feed(v, cnt, gaps);
      if (cnt < 2 * NN) begin
         #1 reset_n = 1'b0;
         #1;
         chk("abort_busy", res_t'(busy), 0);
         chk("abort_in_ready", res_t'(in_ready), 0);
         chk("abort_out_valid", res_t'(out_valid), 0);
         chk("abort_out_data", out_data, 0);
         exp_q.delete();
         @(posedge clk); #3 reset_n = 1'b1;
         @(posedge clk); #1;
      end else begin
         if (noise) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            start    = 1'b1;
            repeat (2) begin
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
            start    = 1'b0;
         end
         wait_idle();
      end
   endtask

   task automatic send1(input op_t d);
      in_valid1 = 1'b1;
      in_data1  = d;
      @(negedge clk);
      chk("in_ready1", res_t'(in_ready1), 1);
      @(posedge clk);
      t_b1 = $time;
      #1;
   endtask

   task automatic run1(input op_t a, input op_t b);
      int t;
      exp1_q.push_back(ext(a) * ext(b));
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      send1(a);
      send1(b);
      lat_pend1 = 1'b1;
      in_valid1 = 1'b0;
      t = 0;
      while ((exp1_q.size() != 0 || busy1) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("results_left1", res_t'(exp1_q.size()), 0);
   endtask

   initial begin
      op_t a[NN], b[NN];
      #3;
      chk("rst_busy", res_t'(busy), 0);
      chk("rst_in_ready", res_t'(in_ready), 0);
      chk("rst_out_valid", res_t'(out_valid), 0);
      chk("rst_done", res_t'(done), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy1", res_t'(busy1), 0);
      chk("rst_out_data1", out_data1, 0);
      #10 reset_n = 1'b1;
      @(posedge clk); #1;
      a = '{1, 2, 3, 4};
      b = '{5, 6, 7, 8};
      run_op(a, b, 0, 0, 0, 2 * NN);
      run_op(a, b, 2, 0, 0, 2 * NN);
      run_op(a, b, 0, 1, 1, 2 * NN);
`ifdef MATMUL_SEQ_SIGNED_EN
      a = '{op_t'(-1), 2, 3, op_t'(-4)};
      b = '{5, op_t'(-6), 7, 8};
      run_op(a, b, 1, 1, 0, 2 * NN);
      a = '{1, 2, 3, 4};
      b = '{5, 6, 7, 8};
`endif
      run_op(a, b, 0, 0, 0, NN + 2);
      run_op(a, b, 0, 0, 0, 2 * NN);
      a = '{default: '1};
      b = '{default: '1};
      run_op(a, b, 1, 0, 0, 2 * NN);
      for (int t = 0; t < 8; t++) begin
         for (int n = 0; n < NN; n++) begin
            a[n] = (t < 4) ? op_t'($urandom) : op_t'($urandom_range(0, 15));
            b[n] = (t < 4) ? op_t'($urandom) : op_t'($urandom_range(0, 15));
         end
         run_op(a, b, t % 3, 1'b1, t[0], 2 * NN);
      end
      run1(7, 6);
      for (int t = 0; t < 3; t++) run1(op_t'($urandom), op_t'($urandom));
      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
